// File: rtl/word_serializer.sv
// Pops one DATA_WIDTH word from an upstream fifo and emits it MSB-first as
// DATA_WIDTH/OUT_WIDTH beats over a valid/ready output stream.
module word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int BEAT_BITS  = 2
) (
  input  logic                  read_clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  read_enable,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [15:0]           words_sent,
  output logic [1:0]            o_dbg_state
);

  localparam int NUM_BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_LOAD = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BEAT_BITS-1:0]  r_beat;
  logic [15:0]           r_words_sent;
  logic                  r_read_enable;
  logic                  w_transfer;
  logic                  w_last_beat;

  // Handshake: a beat moves only when out_valid and out_ready are both high;
  // while out_valid=1 and out_ready=0 the shift register and beat counter
  // hold, so out_data/out_last stay stable until the beat is accepted.
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_transfer  = (r_state == S_SEND) && out_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (!fifo_empty) w_next_state = S_POP;
      S_POP:  w_next_state = S_LOAD;
      S_LOAD: w_next_state = S_SEND;
      S_SEND: begin
        if (w_transfer && w_last_beat) begin
          w_next_state = fifo_empty ? S_IDLE : S_POP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge read_clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_read_enable <= 1'b0;
      r_shift       <= '0;
      r_beat        <= '0;
      r_words_sent  <= '0;
    end else begin
      r_state       <= w_next_state;
      // Registered pop: high exactly during the single POP cycle.
      r_read_enable <= (w_next_state == S_POP);
      if (r_state == S_LOAD) begin
        r_shift <= fifo_data;
        r_beat  <= '0;
      end else if (w_transfer) begin
        r_shift <= r_shift << OUT_WIDTH;
        r_beat  <= r_beat + BEAT_BITS'(1);
        if (w_last_beat) begin
          r_words_sent <= r_words_sent + 16'd1;
        end
      end
    end
  end

  assign read_enable = r_read_enable;
  assign out_valid   = (r_state == S_SEND);
  assign out_data    = r_shift[DATA_WIDTH-1 -: OUT_WIDTH];
  assign out_last    = (r_state == S_SEND) && w_last_beat;
  assign words_sent  = r_words_sent;
  assign o_dbg_state = r_state;

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of the word popped from the upstream fifo.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, meaning width of each output beat; DATA_WIDTH SHALL be an integer multiple of OUT_WIDTH.
REQ-003 SHALL have parameter BEAT_BITS, default 2, meaning counter width, with 2**BEAT_BITS >= DATA_WIDTH/OUT_WIDTH.
REQ-004 SHALL have port read_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the read_clock rising edge.
REQ-006 SHALL have port fifo_empty, input, 1 bit: upstream fifo has no word available.
REQ-007 SHALL have port fifo_data, input, DATA_WIDTH bits: upstream fifo read data.
REQ-008 SHALL have port read_enable, output, 1 bit: registered pop request to the upstream fifo.
REQ-009 SHALL have port out_data, output, OUT_WIDTH bits: current beat.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port out_last, output, 1 bit: current beat is the final beat of a word.
REQ-013 SHALL have port words_sent, output, 16 bits: count of fully transmitted words.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, POP, LOAD, SEND.
REQ-015 In IDLE with fifo_empty=0, SHALL go to POP on the next edge; with fifo_empty=1, SHALL stay in IDLE.
REQ-016 In POP, read_enable SHALL be 1 for exactly one cycle, and the FSM SHALL go to LOAD.
REQ-017 In LOAD, SHALL capture fifo_data into a DATA_WIDTH shift register, clear the beat counter, and go to SEND; read_enable SHALL be 0.
REQ-018 Pop-to-first-beat latency: read_enable high in cycle N, fifo_data sampled at end of cycle N+1, out_valid=1 from cycle N+2.
REQ-019 In SEND, out_valid SHALL be 1 and out_data SHALL equal the upper OUT_WIDTH bits of the shift register (MSB-first order).
REQ-020 Handshake: a beat transfers in a cycle where out_valid=1 and out_ready=1; out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 On transfer, the shift register SHALL shift left by OUT_WIDTH with zero fill, and the beat counter SHALL increment.
REQ-022 out_last SHALL be 1 in SEND only when beat counter = DATA_WIDTH/OUT_WIDTH - 1.
REQ-023 On transfer of the last beat, words_sent SHALL increment modulo 2**16, wrapping from 16'hFFFF to 0.
REQ-024 On last-beat transfer with fifo_empty=0, SHALL go directly to POP (back-to-back); with fifo_empty=1, SHALL go to IDLE.
REQ-025 read_enable SHALL never be 1 outside POP, and SHALL never be 1 while fifo_empty=1 in the preceding IDLE/SEND decision cycle.
REQ-026 out_ready SHALL be ignored outside SEND; out_valid SHALL be 0 in IDLE, POP and LOAD.

Reset
REQ-027 reset=1 at a rising edge SHALL force: state IDLE, read_enable=0, out_valid=0, out_last=0, out_data=0, shift register=0, beat counter=0, words_sent=0.
REQ-028 reset SHALL take priority over every other input in the same cycle.
REQ-029 reset asserted mid-word SHALL discard the partial word with no further beats, and words_sent SHALL not increment for it.

Verification
REQ-030 Single word: fifo_data=32'hA1B2C3D4, fifo_empty falls once -> one read_enable pulse; beats A1,B2,C3,D4 with out_ready=1 on consecutive cycles; out_last only on D4; words_sent=1.
REQ-031 Backpressure: out_ready=0 for 3 cycles during beat B2 -> out_data stays 8'hB2 with out_valid=1; no beat is skipped or duplicated.
REQ-032 Back-to-back: two words queued (fifo_empty=0 throughout) -> second read_enable exactly one cycle after the last beat of the first word transfers; words_sent=2.
REQ-033 Empty fifo: fifo_empty=1 for 20 cycles -> read_enable=0 and out_valid=0 throughout.
REQ-034 Reset mid-word: reset after 2 beats of 32'h11223344 -> next cycle out_valid=0, words_sent=0; a subsequent word 32'h55667788 serializes to 55,66,77,88.
REQ-035 Wrap: words_sent preloaded by sending 65536 words -> words_sent reads 0 after the 65536th word.
